pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage 8-bit pipeline. Combines three hazard sources: load-use (ID vs EX), taken branch resolved in EX, and a data-memory wait handshake. It drives the PC, IF/ID and EX/MEM write enables and the IF/ID and ID/EX flushes, and keeps saturating performance counters. Forwarding muxes are out of scope and remain a separate combinational unit.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/hazard_lu_detect.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard and forwarding logic.
// The forwarding select encodings live here so both units agree on them.
package pipe_pkg;

    localparam int REG_AW_DEF = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FWD_NONE   = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use compare: a load in EX whose destination feeds a source of the ID instruction.
// Register 0 is hardwired to zero, so it never creates a dependency.
module hazard_lu_detect #(
    parameter int REG_AW = 3
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              lu
);

    assign lu = ex_valid & ex_mem_read & (ex_rd != {REG_AW{1'b0}}) & id_valid &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and
// data-memory wait, with saturating stall and redirect counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_write,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [7:0]        flush_count
);

    localparam logic [3:0] BR_PEN_C = 4'(BR_PENALTY);

    state_t           state_r, state_nxt_s;
    logic [3:0]       cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0] stall_cycles_r;
    logic [7:0]       flush_count_r;
    logic             lu_s, lu_eff_s, freeze_s, mem_done_s, redirect_s;
    logic             pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s, ex_mem_write_s;

    hazard_lu_detect #(.REG_AW(REG_AW)) u_lu (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .lu          (lu_s)
    );

    // In LU_STALL the EX stage holds the bubble we inserted, so lu must not re-fire.
    assign lu_eff_s   = lu_s & (state_r == ST_RUN);
    assign freeze_s   = dmem_req & ~dmem_ready;
    assign mem_done_s = dmem_req & dmem_ready;

    // State and penalty counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and penalty-count selection
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN, ST_LU_STALL: begin
                if (freeze_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    if (BR_PEN_C != 4'd0) begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = BR_PEN_C;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (lu_eff_s) begin
                    state_nxt_s = ST_LU_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_done_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            ST_FLUSH: begin
                if (freeze_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Pipeline control outputs; reset forces a held, flushed pipeline
    always_comb begin
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_write_s = 1'b1;
        redirect_s     = 1'b0;
        if (!rstn) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_write_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN, ST_LU_STALL: begin
                    if (freeze_s) begin
                        pc_write_s     = 1'b0;
                        if_id_write_s  = 1'b0;
                        ex_mem_write_s = 1'b0;
                    end else if (branch_taken) begin
                        if_id_flush_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                        redirect_s    = 1'b1;
                    end else if (lu_eff_s) begin
                        pc_write_s    = 1'b0;
                        if_id_write_s = 1'b0;
                        id_ex_flush_s = 1'b1;
                    end else begin
                        pc_write_s = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_done_s) begin
                        pc_write_s = 1'b1;
                    end else begin
                        pc_write_s     = 1'b0;
                        if_id_write_s  = 1'b0;
                        ex_mem_write_s = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (freeze_s) begin
                        pc_write_s     = 1'b0;
                        if_id_write_s  = 1'b0;
                        ex_mem_write_s = 1'b0;
                    end else begin
                        pc_write_s    = 1'b0;
                        if_id_flush_s = 1'b1;
                    end
                end
                default: begin
                    pc_write_s = 1'b1;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_count_r  <= 8'd0;
        end else begin
            if (!pc_write_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (redirect_s && (flush_count_r != 8'hFF)) begin
                flush_count_r <= flush_count_r + 8'd1;
            end
        end
    end

    assign pc_write     = pc_write_s;
    assign if_id_write  = if_id_write_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_flush  = id_ex_flush_s;
    assign ex_mem_write = ex_mem_write_s;
    assign state        = state_r;
    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for the main sequence plus
// hand-written multi-cycle checks (memory wait, zero branch penalty, saturation, mid-flush reset).
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, id_valid, ex_valid, ex_mem_read, branch_taken, dmem_req, dmem_ready;
    logic [2:0] id_rs1, id_rs2, ex_rd;

    logic        a_pc, a_ifw, a_iff, a_idf, a_exw;
    logic [1:0]  a_state;
    logic [15:0] a_stall;
    logic [7:0]  a_flush;
    logic        b_pc, b_ifw, b_iff, b_idf, b_exw;
    logic [1:0]  b_state;
    logic [3:0]  b_stall;
    logic [7:0]  b_flush;

    pipe_hazard_ctrl #(.REG_AW(3), .BR_PENALTY(2), .CNT_W(16)) u_dut_a (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_idf),
        .ex_mem_write(a_exw), .state(a_state), .stall_cycles(a_stall), .flush_count(a_flush)
    );

    pipe_hazard_ctrl #(.REG_AW(3), .BR_PENALTY(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_idf),
        .ex_mem_write(b_exw), .state(b_state), .stall_cycles(b_stall), .flush_count(b_flush)
    );

    typedef struct {
        logic       rstn, idv;
        logic [2:0] rs1, rs2;
        logic       exv, mr;
        logic [2:0] rd;
        logic       br, req, rdy;
        logic [6:0] exp;   // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, state}
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vq[$];

    // Expected output patterns
    localparam logic [6:0] E_RST = 7'b0011000;
    localparam logic [6:0] E_RUN = 7'b1100100;
    localparam logic [6:0] E_LUS = 7'b1100101;
    localparam logic [6:0] E_MWD = 7'b1100110;
    localparam logic [6:0] E_LU  = 7'b0001100;
    localparam logic [6:0] E_BR  = 7'b1111100;
    localparam logic [6:0] E_FL  = 7'b0110111;
    localparam logic [6:0] E_FZ0 = 7'b0000000;
    localparam logic [6:0] E_FZ2 = 7'b0000010;
    localparam logic [6:0] E_FZ3 = 7'b0000011;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic idv, input logic [2:0] rs1,
                                input logic [2:0] rs2, input logic exv, input logic mr,
                                input logic [2:0] rd, input logic br, input logic req,
                                input logic rdy, input logic [6:0] exp);
        vec_t v;
        v.rstn = r; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.exv = exv; v.mr = mr;
        v.rd = rd; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input logic idv, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic exv, input logic mr, input logic [2:0] rd,
                         input logic br, input logic req, input logic rdy);
        id_valid = idv; id_rs1 = rs1; id_rs2 = rs2; ex_valid = exv; ex_mem_read = mr;
        ex_rd = rd; branch_taken = br; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        rstn = 1'b1;
    endtask

    function automatic logic [6:0] a_out();
        return {a_pc, a_ifw, a_iff, a_idf, a_exw, a_state};
    endfunction

    initial begin
        rstn = 1'b0;
        drive(1'b1, 3'd7, 3'd7, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);

        //            rstn idv rs1   rs2   exv mr  rd    br   req  rdy  expected
        vq.push_back(mk(1'b0, 1'b1, 3'd7, 3'd7, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, E_RST));
        vq.push_back(mk(1'b0, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, E_RST));
        vq.push_back(mk(1'b0, 1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, E_RST));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_RUN));
        vq.push_back(mk(1'b1, 1'b1, 3'd5, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, E_LU));
        vq.push_back(mk(1'b1, 1'b1, 3'd5, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, E_LUS));
        vq.push_back(mk(1'b1, 1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, E_RUN));
        vq.push_back(mk(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, E_RUN));
        vq.push_back(mk(1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, E_RUN));
        vq.push_back(mk(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, E_BR));
        vq.push_back(mk(1'b1, 1'b1, 3'd6, 3'd6, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, E_FL));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_FL));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_RUN));
        vq.push_back(mk(1'b1, 1'b1, 3'd2, 3'd0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, E_FZ0));
        vq.push_back(mk(1'b1, 1'b1, 3'd2, 3'd0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, E_FZ2));
        vq.push_back(mk(1'b1, 1'b1, 3'd2, 3'd0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, E_MWD));
        vq.push_back(mk(1'b1, 1'b1, 3'd2, 3'd0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, E_BR));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_FZ3));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, E_FL));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_FL));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_RUN));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_FZ0));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, E_FZ2));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, E_MWD));
        vq.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_RUN));

        // Main table: inputs applied just after the edge, outputs checked mid-cycle.
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rstn = vq[i].rstn;
            drive(vq[i].idv, vq[i].rs1, vq[i].rs2, vq[i].exv, vq[i].mr, vq[i].rd,
                  vq[i].br, vq[i].req, vq[i].rdy);
            #3;
            chk($sformatf("vec%0d", i), 32'(a_out()), 32'(vq[i].exp));
            if (i == 2) begin
                chk("rst_stall", 32'(a_stall), 32'd0);
                chk("rst_flush", 32'(a_flush), 32'd0);
            end
            next_cycle();
        end
        // Stalls: 1 load-use + 2 flush + 2 freeze + 3 flush(incl. frozen) + 2 freeze
        chk("tbl_stall", 32'(a_stall), 32'd10);
        chk("tbl_flush", 32'(a_flush), 32'd2);

        // Memory wait: four frozen cycles then the ready cycle.
        do_reset();
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
            #3;
            chk($sformatf("mw_frz%0d", k), 32'({a_pc, a_ifw, a_exw}), 32'd0);
            next_cycle();
        end
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        #3;
        chk("mw_ready", 32'({a_pc, a_ifw, a_exw, a_state}), 32'b11110);
        next_cycle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("mw_state", 32'(a_state), 32'd0);
        chk("mw_stall", 32'(a_stall), 32'd4);

        // Zero-penalty branch returns straight to RUN; then reset mid-flush on the other instance.
        do_reset();
        next_cycle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        #3;
        chk("b0_redir", 32'({b_pc, b_iff, b_idf}), 32'b111);
        next_cycle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("b0_after", 32'({b_pc, b_iff, b_idf, b_state}), 32'b10000);
        chk("b0_flush", 32'(b_flush), 32'd1);
        chk("b0_stall", 32'(b_stall), 32'd0);
        chk("a_inflush", 32'({a_state, a_flush}), {22'd0, 2'd3, 8'd1});
        rstn = 1'b0;
        #1;
        chk("midrst_state", 32'(a_state), 32'd0);
        chk("midrst_cnt", 32'({a_stall, a_flush}), 32'd0);
        chk("midrst_out", 32'({a_pc, a_iff, a_idf}), 32'b011);
        next_cycle();
        rstn = 1'b1;

        // Saturation: 20 frozen cycles, 4-bit counter pins at 15.
        next_cycle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        repeat (20) next_cycle();
        chk("sat_b", 32'(b_stall), 32'd15);
        chk("sat_a", 32'(a_stall), 32'd20);
        chk("sat_state", 32'(a_state), 32'd2);
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
